inst_fetch_buffer: RTL
======================

// Module: inst_fetch_buffer
// PURPOSE
// - Dual-enqueue / dual-dequeue instruction queue between fetch and dual-issue decode.
// - Per cycle, fetch presents up to two instructions with their PCs. The buffer accepts 0, 1 or 2 of them.
// - Acceptance is returned as inst_ok_1/inst_ok_2. The PC controller uses these to pick the next fetch PC and to flush stale fetches.
// - Up to two oldest entries are presented in program order to the issue stage, which takes 0, 1 or 2.
// PARAMETERS
// - WIDTH  32  PC and instruction word width
// - DEPTH  16  number of entries; must be a power of two, >= 4
// PORTS
// - clk          in   1      single clock, rising edge
// - rst          in   1      synchronous, active-high reset
// - flush        in   1      branch redirect; discard all contents
// - fetch_vld_1  in   1      fetch slot 1 holds an instruction
// - fetch_vld_2  in   1      fetch slot 2 holds an instruction (PC = slot 1 PC + 4)
// - fetch_pc_1   in   WIDTH  PC of slot 1
// - fetch_pc_2   in   WIDTH  PC of slot 2
// - fetch_inst_1 in   WIDTH  instruction word, slot 1
// - fetch_inst_2 in   WIDTH  instruction word, slot 2
// - inst_ok_1    out  1      slot 1 accepted this cycle
// - inst_ok_2    out  1      slot 2 accepted this cycle
// - out_vld_1    out  1      head entry valid
// - out_vld_2    out  1      head+1 entry valid
// - out_pc_1     out  WIDTH  PC of head entry
// - out_pc_2     out  WIDTH  PC of head+1 entry
// - out_inst_1   out  WIDTH  instruction at head
// - out_inst_2   out  WIDTH  instruction at head+1
// - issue_take_1 in   1      issue consumes head this cycle
// - issue_take_2 in   1      issue consumes head+1; honoured only together with take_1
// - count        out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
// - Reset: head=tail=count=0. All outputs are 0 in the cycle after rst is sampled. rst has priority over flush and all traffic, including mid-operation.
// - State: head ptr, tail ptr ($clog2(DEPTH) bits, natural wrap), count (one extra bit). The entry array is not reset.
// - free = DEPTH - count, taken from the registered count. Same-cycle dequeues never create space for same-cycle enqueues.
// - inst_ok_1 = fetch_vld_1 & free>=1 & !flush.
// - inst_ok_2 = fetch_vld_2 & inst_ok_1 & free>=2. Slot 2 is never accepted without slot 1. fetch_vld_2 with !fetch_vld_1 gives inst_ok_2=0.
// - inst_ok_* are combinational, valid in the same cycle as fetch_vld_*. Accepted entries are written at tail and tail+1. tail advances by the number accepted.
// - out_vld_1 = count>=1 & !flush; out_vld_2 = count>=2 & !flush.
// - out_pc/out_inst are read combinationally at head and head+1, so an enqueued entry is visible 1 cycle after acceptance. There is no bypass.
// - deq = take_1&out_vld_1 + take_1&take_2&out_vld_2. A take on an invalid slot is ignored. take_2 without take_1 is ignored. head advances by deq.
// - count_next = count + enq - deq. Simultaneous enq and deq are legal; the result must stay in [0, DEPTH].
// - Wrap: pointers modulo DEPTH. Head+1 and tail+1 wrap independently: an entry pair may straddle index DEPTH-1 -> 0.
// - Full (count==DEPTH): inst_ok_1=inst_ok_2=0. With count==DEPTH-1, only slot 1 is accepted.
// - Empty (count==0): out_vld_1=out_vld_2=0; takes are ignored.
// - Flush: all enq and deq are suppressed that cycle. Next cycle head=tail=count=0. flush with rst: rst wins (same result).
// - Latency: fetch-accept -> out_vld = 1 cycle; take -> pointer update = 1 cycle.
// STRUCTURE
// - Shared pkg cpu_pkg:
//   - typedef struct packed {logic [WIDTH-1:0] pc; logic [WIDTH-1:0] inst;} fetch_entry_t
//   - localparam IFB_DEPTH = 16
// - Sub-module ifb_storage: DEPTH x fetch_entry_t register array.
//   - 2 write ports (wr_en/idx/data x2).
//   - 2 async read ports (head, head+1).
//   - No reset.
// - Pointer, count and handshake logic stay in inst_fetch_buffer.
// TESTING
// - Reset, then 2 fetches/cycle, no takes.
//   - inst_ok=11 for 8 cycles; count=16.
//   - Then cycle 9: inst_ok=00.
//   - count=15 -> only inst_ok_1=1.
// - Fill 3 entries (PC 0x0,0x4,0x8), take_1&take_2.
//   - out_pc_1=0x0, out_pc_2=0x4.
//   - Next cycle: out_pc_1=0x8, out_vld_2=0, count=1.
// - Wrap: cycle 20 entries through DEPTH=16 with mixed 1/2 takes.
//   - out_pc sequence is strictly +4 from 0x0.
//   - Pair straddling index 15->0 is read correctly.
// - count=16 with take_1&take_2 and fetch 11 in the same cycle.
//   - inst_ok=00; next cycle count=14.
// - flush with count=9, fetch 11, take 11.
//   - Same cycle: inst_ok=00, out_vld=00.
//   - Next cycle: count=0. Refill from PC 0x100: out_pc_1=0x100 one cycle later.
// - Illegal take_2 without take_1 at count=2 -> count stays 2; rst mid-fill -> count=0 next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
//==============================================================
// Package : cpu_pkg
// Shared CPU front-end types and sizing constants.
// Rev     : 1.0
//==============================================================
`default_nettype none

package cpu_pkg;

  localparam int IFB_WIDTH = 32;
  localparam int IFB_DEPTH = 16;

  typedef struct packed {
    logic [IFB_WIDTH-1:0] pc;
    logic [IFB_WIDTH-1:0] inst;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/ifb_storage.sv
//==============================================================
// Module : ifb_storage
// Entry array for the fetch buffer: two write ports, two async reads.
// Rev    : 1.0
//==============================================================
`default_nettype none

module ifb_storage
  import cpu_pkg::*;
#(
  parameter int DEPTH = IFB_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en_1,
  input  logic [$clog2(DEPTH)-1:0] wr_idx_1,
  input  fetch_entry_t             wr_data_1,
  input  logic                     wr_en_2,
  input  logic [$clog2(DEPTH)-1:0] wr_idx_2,
  input  fetch_entry_t             wr_data_2,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_1,
  output fetch_entry_t             rd_data_1,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_2,
  output fetch_entry_t             rd_data_2
);

  // Contents are only meaningful below the occupancy count, so no reset.
  fetch_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_1) r_mem[wr_idx_1] <= wr_data_1;
    if (wr_en_2) r_mem[wr_idx_2] <= wr_data_2;
  end

  assign rd_data_1 = r_mem[rd_idx_1];
  assign rd_data_2 = r_mem[rd_idx_2];

endmodule

`default_nettype wire

// File: rtl/inst_fetch_buffer.sv
//==============================================================
// Module : inst_fetch_buffer
// Dual-enqueue / dual-dequeue instruction queue, fetch -> dual issue.
// Rev    : 1.0
//==============================================================
`default_nettype none

module inst_fetch_buffer
  import cpu_pkg::*;
#(
  parameter int WIDTH = IFB_WIDTH,
  parameter int DEPTH = IFB_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   fetch_vld_1,
  input  logic                   fetch_vld_2,
  input  logic [WIDTH-1:0]       fetch_pc_1,
  input  logic [WIDTH-1:0]       fetch_pc_2,
  input  logic [WIDTH-1:0]       fetch_inst_1,
  input  logic [WIDTH-1:0]       fetch_inst_2,
  output logic                   inst_ok_1,
  output logic                   inst_ok_2,
  output logic                   out_vld_1,
  output logic                   out_vld_2,
  output logic [WIDTH-1:0]       out_pc_1,
  output logic [WIDTH-1:0]       out_pc_2,
  output logic [WIDTH-1:0]       out_inst_1,
  output logic [WIDTH-1:0]       out_inst_2,
  input  logic                   issue_take_1,
  input  logic                   issue_take_2,
  output logic [$clog2(DEPTH):0] count
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

  logic [c_AW-1:0] r_head;
  logic [c_AW-1:0] r_tail;
  logic [c_CW-1:0] r_count;

  logic [c_CW-1:0] w_free;
  logic            w_ok_1;
  logic            w_ok_2;
  logic            w_vld_1;
  logic            w_vld_2;
  logic [1:0]      w_enq;
  logic [1:0]      w_deq;
  logic [c_AW-1:0] w_head_1;
  logic [c_AW-1:0] w_tail_1;
  fetch_entry_t    w_wr_1;
  fetch_entry_t    w_wr_2;
  fetch_entry_t    w_rd_1;
  fetch_entry_t    w_rd_2;

  // Space comes only from the registered count; same-cycle dequeues do not free slots.
  assign w_free  = c_DEPTH - r_count;
  assign w_ok_1  = fetch_vld_1 & (w_free != '0) & ~flush;
  assign w_ok_2  = fetch_vld_2 & w_ok_1 & (w_free >= c_CW'(2));
  assign w_vld_1 = (r_count != '0) & ~flush;
  assign w_vld_2 = (r_count >= c_CW'(2)) & ~flush;

  assign w_enq = {1'b0, w_ok_1} + {1'b0, w_ok_2};
  assign w_deq = {1'b0, issue_take_1 & w_vld_1}
               + {1'b0, issue_take_1 & issue_take_2 & w_vld_2};

  // Pair neighbours wrap independently so a pair may straddle the array end.
  assign w_head_1 = r_head + c_AW'(1);
  assign w_tail_1 = r_tail + c_AW'(1);

  assign w_wr_1 = {fetch_pc_1, fetch_inst_1};
  assign w_wr_2 = {fetch_pc_2, fetch_inst_2};

  ifb_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk       (clk),
    .wr_en_1   (w_ok_1),
    .wr_idx_1  (r_tail),
    .wr_data_1 (w_wr_1),
    .wr_en_2   (w_ok_2),
    .wr_idx_2  (w_tail_1),
    .wr_data_2 (w_wr_2),
    .rd_idx_1  (r_head),
    .rd_data_1 (w_rd_1),
    .rd_idx_2  (w_head_1),
    .rd_data_2 (w_rd_2)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + c_AW'(w_deq);
      r_tail  <= r_tail + c_AW'(w_enq);
      r_count <= r_count + c_CW'(w_enq) - c_CW'(w_deq);
    end
  end

  // Data is masked when invalid so unreset storage never reaches the ports.
  assign inst_ok_1  = w_ok_1;
  assign inst_ok_2  = w_ok_2;
  assign out_vld_1  = w_vld_1;
  assign out_vld_2  = w_vld_2;
  assign out_pc_1   = w_vld_1 ? w_rd_1.pc   : '0;
  assign out_inst_1 = w_vld_1 ? w_rd_1.inst : '0;
  assign out_pc_2   = w_vld_2 ? w_rd_2.pc   : '0;
  assign out_inst_2 = w_vld_2 ? w_rd_2.inst : '0;
  assign count      = r_count;

endmodule

`default_nettype wire
